// File: rtl/alu_pkg.sv
// Shared definitions for the ALU front-end sequencer: opcodes, FSM encoding,
// strobe vector bit positions and opcode classification helpers.
package alu_pkg;

  localparam int ALU_DATA_W = 4;
  localparam int ALU_OP_W   = 4;

  localparam logic [ALU_OP_W-1:0] OP_ADD = 4'd0;
  localparam logic [ALU_OP_W-1:0] OP_SUB = 4'd1;
  localparam logic [ALU_OP_W-1:0] OP_LSH = 4'd2;
  localparam logic [ALU_OP_W-1:0] OP_RSH = 4'd3;
  localparam logic [ALU_OP_W-1:0] OP_AND = 4'd4;
  localparam logic [ALU_OP_W-1:0] OP_OR  = 4'd5;
  localparam logic [ALU_OP_W-1:0] OP_XOR = 4'd6;
  localparam logic [ALU_OP_W-1:0] OP_INV = 4'd7;
  localparam logic [ALU_OP_W-1:0] OP_CLR = 4'd8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_EXEC = 2'd2,
    ST_RESP = 2'd3
  } state_t;

  localparam int NUM_STROBES = 10;
  localparam int S_ADD = 0;
  localparam int S_SUB = 1;
  localparam int S_LSR = 2;
  localparam int S_LSH = 3;
  localparam int S_RSH = 4;
  localparam int S_AND = 5;
  localparam int S_OR  = 6;
  localparam int S_XOR = 7;
  localparam int S_INV = 8;
  localparam int S_CLR = 9;

  function automatic logic is_shift(input logic [ALU_OP_W-1:0] op);
    return (op == OP_LSH) || (op == OP_RSH);
  endfunction

  function automatic logic is_legal(input logic [ALU_OP_W-1:0] op);
    return op <= OP_CLR;
  endfunction

endpackage

// File: rtl/alu_op_decoder.sv
// Combinational opcode decoder: produces the one-hot ALU strobe vector for
// the shift-register load cycle and the execute cycle.
module alu_op_decoder
  import alu_pkg::*;
(
  input  logic [ALU_OP_W-1:0]    op,
  input  logic                   load_en,
  input  logic                   exec_en,
  output logic [NUM_STROBES-1:0] strobes
);

  always_comb begin
    strobes = '0;
    if (load_en) begin
      strobes[S_LSR] = 1'b1;
    end else if (exec_en) begin
      case (op)
        OP_ADD:  strobes[S_ADD] = 1'b1;
        OP_SUB:  strobes[S_SUB] = 1'b1;
        OP_LSH:  strobes[S_LSH] = 1'b1;
        OP_RSH:  strobes[S_RSH] = 1'b1;
        OP_AND:  strobes[S_AND] = 1'b1;
        OP_OR:   strobes[S_OR]  = 1'b1;
        OP_XOR:  strobes[S_XOR] = 1'b1;
        OP_INV:  strobes[S_INV] = 1'b1;
        // illegal codes only reach EXEC when trapping is disabled; they act as CLR
        default: strobes[S_CLR] = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/alu_sequencer.sv
// Request/response front-end for the 4-bit ALU. Build option
// ALU_SEQ_ILLEGAL_TRAP_EN reports illegal opcodes via rsp_err instead of running CLR.
//
// state | meaning
// IDLE  | ready for a request; operands and opcode latched on accept
// LOAD  | alu_lsr pulse, shift register loads alu_in1
// EXEC  | single opcode strobe; result and flag captured at cycle end
// RESP  | response held until rsp_ready
module alu_sequencer
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = 4,
  parameter int OP_WIDTH   = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [OP_WIDTH-1:0]   req_op,
  input  logic [DATA_WIDTH-1:0] req_a,
  input  logic [DATA_WIDTH-1:0] req_b,
  output logic [DATA_WIDTH-1:0] alu_in1,
  output logic [DATA_WIDTH-1:0] alu_in2,
  output logic                  alu_add,
  output logic                  alu_sub,
  output logic                  alu_lsr,
  output logic                  alu_lsh,
  output logic                  alu_rsh,
  output logic                  alu_and,
  output logic                  alu_or,
  output logic                  alu_xor,
  output logic                  alu_inv,
  output logic                  alu_clr,
  input  logic [DATA_WIDTH-1:0] alu_out,
  input  logic                  alu_overflow,
  input  logic                  alu_shift_flag,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  rsp_flag,
  output logic                  rsp_err,
  output logic                  busy
);

  state_t                  state, state_next;
  logic [OP_WIDTH-1:0]     op_q;
  logic [NUM_STROBES-1:0]  strobes;
  logic                    accept;
  logic                    flag_sel;

  assign accept    = (state == ST_IDLE) && req_valid;
  assign req_ready = (state == ST_IDLE);
  assign rsp_valid = (state == ST_RESP);
  assign busy      = (state != ST_IDLE);

  alu_op_decoder u_decoder (
    .op      (op_q),
    .load_en (state == ST_LOAD),
    .exec_en (state == ST_EXEC),
    .strobes (strobes)
  );

  assign alu_add = strobes[S_ADD];
  assign alu_sub = strobes[S_SUB];
  assign alu_lsr = strobes[S_LSR];
  assign alu_lsh = strobes[S_LSH];
  assign alu_rsh = strobes[S_RSH];
  assign alu_and = strobes[S_AND];
  assign alu_or  = strobes[S_OR];
  assign alu_xor = strobes[S_XOR];
  assign alu_inv = strobes[S_INV];
  assign alu_clr = strobes[S_CLR];

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (req_valid) begin
          if (is_shift(req_op)) begin
            state_next = ST_LOAD;
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
          end else if (!is_legal(req_op)) begin
            state_next = ST_RESP;
`endif
          end else begin
            state_next = ST_EXEC;
          end
        end
      end
      ST_LOAD: state_next = ST_EXEC;
      ST_EXEC: state_next = ST_RESP;
      ST_RESP: if (rsp_ready) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    flag_sel = 1'b0;
    case (op_q)
      OP_ADD, OP_SUB: flag_sel = alu_overflow;
      OP_LSH, OP_RSH: flag_sel = alu_shift_flag;
      default:        flag_sel = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= ST_IDLE;
      op_q     <= '0;
      alu_in1  <= '0;
      alu_in2  <= '0;
      rsp_data <= '0;
      rsp_flag <= 1'b0;
    end else begin
      state <= state_next;
      if (accept) begin
        alu_in1 <= req_a;
        alu_in2 <= req_b;
        op_q    <= req_op;
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
        if (!is_legal(req_op)) begin
          rsp_data <= '0;
          rsp_flag <= 1'b0;
        end
`endif
      end
      if (state == ST_EXEC) begin
        rsp_data <= alu_out;
        rsp_flag <= flag_sel;
      end
    end
  end

`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
  logic err_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      err_q <= 1'b0;
    end else if (accept) begin
      err_q <= !is_legal(req_op);
    end
  end

  assign rsp_err = err_q;
`else
  assign rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer with a behavioural ALU stub and a
// response scoreboard; honours ALU_SEQ_ILLEGAL_TRAP_EN when defined.
module tb_alu_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [3:0] req_op = '0, req_a = '0, req_b = '0;
  logic [3:0] alu_in1, alu_in2, alu_out;
  logic       alu_add, alu_sub, alu_lsr, alu_lsh, alu_rsh;
  logic       alu_and, alu_or, alu_xor, alu_inv, alu_clr;
  logic       alu_overflow, alu_shift_flag;
  logic       rsp_valid, rsp_ready = 1'b0;
  logic [3:0] rsp_data;
  logic       rsp_flag, rsp_err, busy;

  localparam int B_ADD = 0, B_SUB = 1, B_LSR = 2, B_LSH = 3, B_RSH = 4;
  localparam int B_AND = 5, B_OR = 6, B_XOR = 7, B_INV = 8, B_CLR = 9;

  typedef struct packed {
    logic [3:0] data;
    logic       flag;
    logic       err;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  logic [9:0] strobes;
  logic [3:0] sr = '0;
  logic [4:0] wide;

  always #5 clk = ~clk;

  assign strobes = {alu_clr, alu_inv, alu_xor, alu_or, alu_and,
                    alu_rsh, alu_lsh, alu_lsr, alu_sub, alu_add};

  alu_sequencer dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b),
    .alu_in1(alu_in1), .alu_in2(alu_in2),
    .alu_add(alu_add), .alu_sub(alu_sub), .alu_lsr(alu_lsr), .alu_lsh(alu_lsh),
    .alu_rsh(alu_rsh), .alu_and(alu_and), .alu_or(alu_or), .alu_xor(alu_xor),
    .alu_inv(alu_inv), .alu_clr(alu_clr),
    .alu_out(alu_out), .alu_overflow(alu_overflow), .alu_shift_flag(alu_shift_flag),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_flag(rsp_flag), .rsp_err(rsp_err), .busy(busy)
  );

  // Behavioural ALU: shift register loads on alu_lsr, everything else combinational.
  always @(posedge clk) if (alu_lsr) sr <= alu_in1;

  always_comb begin
    alu_out = '0;
    alu_overflow = 1'b0;
    alu_shift_flag = 1'b0;
    wide = '0;
    if (alu_add) begin
      wide = {1'b0, alu_in1} + {1'b0, alu_in2};
      alu_out = wide[3:0];
      alu_overflow = wide[4];
    end else if (alu_sub) begin
      wide = {1'b0, alu_in1} - {1'b0, alu_in2};
      alu_out = wide[3:0];
      alu_overflow = wide[4];
    end else if (alu_lsh) begin
      alu_out = {sr[2:0], 1'b0};
      alu_shift_flag = sr[3];
    end else if (alu_rsh) begin
      alu_out = {1'b0, sr[3:1]};
      alu_shift_flag = sr[0];
    end else if (alu_and) alu_out = alu_in1 & alu_in2;
    else if (alu_or)  alu_out = alu_in1 | alu_in2;
    else if (alu_xor) alu_out = alu_in1 ^ alu_in2;
    else if (alu_inv) alu_out = ~alu_in1;
  end

  // Response scoreboard and strobe exclusivity monitor.
  always @(negedge clk) begin
    if (reset) begin
      total++;
      if ($countones(strobes) > 1) begin
        bad++;
        $display("FAIL onehot: strobes=%b required at most one high", strobes);
      end
      if (rsp_valid && rsp_ready) begin
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL unexpected_rsp: got data=%h flag=%b err=%b, required no response",
                   rsp_data, rsp_flag, rsp_err);
        end else begin
          exp_t e;
          e = sb.pop_front();
          if ({rsp_data, rsp_flag, rsp_err} !== {e.data, e.flag, e.err}) begin
            bad++;
            $display("FAIL sb_rsp: got data=%h flag=%b err=%b, required data=%h flag=%b err=%b",
                     rsp_data, rsp_flag, rsp_err, e.data, e.flag, e.err);
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b,
                        input logic [3:0] d, input logic f, input logic e, input bit push);
    total++;
    if (req_ready !== 1'b1) begin
      bad++;
      $display("FAIL accept_ready: req_ready=%b required 1", req_ready);
    end
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
    if (push) sb.push_back('{data: d, flag: f, err: e});
    step();
    req_valid = 1'b0;
  endtask

  task automatic run_op(input string name, input logic [3:0] op, input logic [3:0] a,
                        input logic [3:0] b, input logic [3:0] d, input logic f,
                        input int idx, input bit shift);
    logic [9:0] m;
    rsp_ready = 1'b1;
    accept(op, a, b, d, f, 1'b0, 1'b1);
    if (shift) begin
      m = 10'd1 << B_LSR;
      total++;
      if (strobes !== m) begin
        bad++;
        $display("FAIL %s_load: strobes=%b required %b", name, strobes, m);
      end
      step();
    end
    m = 10'd1 << idx;
    total++;
    if (strobes !== m || rsp_valid !== 1'b0) begin
      bad++;
      $display("FAIL %s_exec: strobes=%b rsp_valid=%b required %b/0", name, strobes, rsp_valid, m);
    end
    step();
    total++;
    if (rsp_valid !== 1'b1 || rsp_data !== d || rsp_flag !== f || rsp_err !== 1'b0 || strobes !== '0) begin
      bad++;
      $display("FAIL %s_rsp: valid=%b data=%h flag=%b err=%b strobes=%b required 1/%h/%b/0/0",
               name, rsp_valid, rsp_data, rsp_flag, rsp_err, strobes, d, f);
    end
    step();
    total++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      bad++;
      $display("FAIL %s_done: rsp_valid=%b req_ready=%b required 0/1", name, rsp_valid, req_ready);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) step();
    total++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || busy !== 1'b0 || strobes !== '0 ||
        rsp_data !== '0 || rsp_flag !== 1'b0 || rsp_err !== 1'b0 ||
        alu_in1 !== '0 || alu_in2 !== '0) begin
      bad++;
      $display("FAIL reset_state: ready=%b valid=%b busy=%b strobes=%b data=%h flag=%b err=%b in1=%h in2=%h",
               req_ready, rsp_valid, busy, strobes, rsp_data, rsp_flag, rsp_err, alu_in1, alu_in2);
    end
    reset = 1'b1;
    step();
  endtask

  task automatic test_add();
    run_op("add", 4'd0, 4'h9, 4'h8, 4'h1, 1'b1, B_ADD, 1'b0);
    run_op("add_wrap", 4'd0, 4'hF, 4'h1, 4'h0, 1'b1, B_ADD, 1'b0);
    run_op("inv", 4'd7, 4'h5, 4'h0, 4'hA, 1'b0, B_INV, 1'b0);
  endtask

  task automatic test_shift();
    run_op("lsh", 4'd2, 4'hA, 4'h0, 4'h4, 1'b1, B_LSH, 1'b1);
    run_op("rsh", 4'd3, 4'h3, 4'h0, 4'h1, 1'b1, B_RSH, 1'b1);
  endtask

  task automatic test_backpressure();
    rsp_ready = 1'b0;
    accept(4'd1, 4'h2, 4'h5, 4'hD, 1'b1, 1'b0, 1'b1);
    req_valid = 1'b1; req_op = 4'd0; req_a = 4'h1; req_b = 4'h1;
    step();
    for (int i = 0; i < 4; i++) begin
      total++;
      if (rsp_valid !== 1'b1 || rsp_data !== 4'hD || rsp_flag !== 1'b1 ||
          req_ready !== 1'b0 || busy !== 1'b1 || alu_in1 !== 4'h2 || alu_in2 !== 4'h5) begin
        bad++;
        $display("FAIL sub_hold%0d: valid=%b data=%h flag=%b ready=%b busy=%b in1=%h in2=%h required 1/d/1/0/1/2/5",
                 i, rsp_valid, rsp_data, rsp_flag, req_ready, busy, alu_in1, alu_in2);
      end
      if (i < 3) step();
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    step();
    total++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL sub_release: valid=%b ready=%b busy=%b required 0/1/0", rsp_valid, req_ready, busy);
    end
  endtask

  task automatic test_back_to_back();
    run_op("and", 4'd4, 4'hC, 4'hA, 4'h8, 1'b0, B_AND, 1'b0);
    run_op("xor", 4'd6, 4'hC, 4'hA, 4'h6, 1'b0, B_XOR, 1'b0);
    run_op("or",  4'd5, 4'hC, 4'hA, 4'hE, 1'b0, B_OR,  1'b0);
  endtask

  task automatic test_reset_abort();
    rsp_ready = 1'b1;
    accept(4'd3, 4'h3, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
    total++;
    if (alu_lsr !== 1'b1) begin
      bad++;
      $display("FAIL abort_load: alu_lsr=%b required 1", alu_lsr);
    end
    reset = 1'b0;
    step();
    reset = 1'b1;
    total++;
    if (busy !== 1'b0 || strobes !== '0 || rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      bad++;
      $display("FAIL abort_idle: busy=%b strobes=%b valid=%b ready=%b required 0/0/0/1",
               busy, strobes, rsp_valid, req_ready);
    end
    for (int i = 0; i < 5; i++) begin
      step();
      total++;
      if (rsp_valid !== 1'b0 || strobes !== '0) begin
        bad++;
        $display("FAIL abort_quiet%0d: valid=%b strobes=%b required 0/0", i, rsp_valid, strobes);
      end
    end
  endtask

  task automatic test_illegal();
    rsp_ready = 1'b1;
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
    accept(4'hB, 4'h5, 4'h3, 4'h0, 1'b0, 1'b1, 1'b1);
    total++;
    if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_data !== 4'h0 || rsp_flag !== 1'b0 || strobes !== '0) begin
      bad++;
      $display("FAIL illegal_trap: valid=%b err=%b data=%h flag=%b strobes=%b required 1/1/0/0/0",
               rsp_valid, rsp_err, rsp_data, rsp_flag, strobes);
    end
    step();
    total++;
    if (rsp_valid !== 1'b0) begin
      bad++;
      $display("FAIL illegal_done: rsp_valid=%b required 0", rsp_valid);
    end
`else
    run_op("illegal_clr", 4'hB, 4'h5, 4'h3, 4'h0, 1'b0, B_CLR, 1'b0);
`endif
    run_op("clr", 4'd8, 4'h7, 4'h7, 4'h0, 1'b0, B_CLR, 1'b0);
  endtask

  initial begin
    test_reset();
    test_add();
    test_shift();
    test_backpressure();
    test_back_to_back();
    test_reset_abort();
    test_illegal();
    repeat (2) step();
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL sb_drain: %0d responses outstanding, required 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
- Front-end controller for the 4-bit arithmetic logic unit.
- Accepts one opcode/operand request at a time over a valid/ready handshake.
- Drives the ALU's one-hot control strobes and operands, and sequences the two-step shift (load the shift register, then shift).
- Captures the result and flag and returns them over a valid/ready response handshake.

Parameters:
- DATA_WIDTH, 4: operand/result width; must match the ALU datapath.
- OP_WIDTH, 4: opcode field width.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  sequencer can accept a request
- req_op  in  OP_WIDTH  opcode
- req_a  in  DATA_WIDTH  operand 1
- req_b  in  DATA_WIDTH  operand 2
- alu_in1  out  DATA_WIDTH  ALU operand 1
- alu_in2  out  DATA_WIDTH  ALU operand 2
- alu_add, alu_sub, alu_lsr, alu_lsh, alu_rsh, alu_and, alu_or, alu_xor, alu_inv, alu_clr  out  1 each  ALU strobes
- alu_out  in  DATA_WIDTH  ALU result
- alu_overflow  in  1  ALU overflow/borrow
- alu_shift_flag  in  1  bit shifted out by the shifter
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts response
- rsp_data  out  DATA_WIDTH  captured result
- rsp_flag  out  1  captured flag
- rsp_err  out  1  illegal opcode reported
- busy  out  1  state != IDLE

Behaviour:
- Reset: clk is the clock; reset is synchronous, active-low.
  - While reset=0 at a posedge: state=IDLE; operand regs, rsp_data, rsp_flag, rsp_err, rsp_valid = 0; all strobes = 0.
  - Reset mid-operation abandons the operation; no response is produced.
- Opcodes: ADD=0, SUB=1, LSH=2, RSH=3, AND=4, OR=5, XOR=6, INV=7, CLR=8; 9..15 are illegal.
- FSM states: IDLE, LOAD, EXEC, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid: register req_a/req_b into alu_in1/alu_in2 and latch the opcode.
  - Next state: LSH/RSH -> LOAD; illegal -> see Optional Feature; otherwise -> EXEC.
- LOAD:
  - alu_lsr=1 for exactly one cycle; the shift register loads alu_in1 at the closing edge.
  - Next state: EXEC.
- EXEC:
  - Exactly one strobe, matching the opcode, is asserted for one cycle.
  - At the closing edge, capture alu_out into rsp_data.
  - rsp_flag: alu_overflow for ADD/SUB; alu_shift_flag for LSH/RSH; 0 for logic ops and CLR.
  - Next state: RESP.
- RESP:
  - rsp_valid=1, with rsp_data/rsp_flag/rsp_err held stable.
  - On rsp_ready: next state IDLE and rsp_valid drops next cycle.
- Latency (accept edge T):
  - Non-shift ops: rsp_valid high from T+2.
  - Shift ops: rsp_valid high from T+3.
  - Next accept is no earlier than the cycle after the response handshake.
- Strobe and operand rules:
  - At most one strobe is high in any cycle; all strobes are 0 in IDLE and RESP.
  - alu_lsr is high only in LOAD.
  - alu_in1/alu_in2 are stable from accept through EXEC.
- Handshake rules:
  - req_ready=0 in all states except IDLE; req_valid outside IDLE is ignored.
  - rsp_ready outside RESP is ignored.
  - rsp_valid never drops without rsp_ready, except on reset.
- Arithmetic: wrap-around results come from the ALU unmodified (e.g. 0xF+0x1 -> data 0x0, flag 1).

Optional Feature:
- Macro: ALU_SEQ_ILLEGAL_TRAP_EN.
- Defined: an illegal opcode goes IDLE -> RESP directly with no strobe, rsp_data=0, rsp_flag=0, rsp_err=1.
- Undefined: an illegal opcode decodes as CLR via the EXEC path, and rsp_err is tied to 0.

Decomposition:
- Shared package alu_pkg:
  - Opcode localparams (OP_ADD..OP_CLR).
  - State encoding (ST_IDLE, ST_LOAD, ST_EXEC, ST_RESP).
  - A function is_shift(op).
- One natural sub-module: alu_op_decoder, purely combinational, mapping (opcode, exec_en) to the one-hot strobe vector.
- The FSM, operand registers and response registers stay in alu_sequencer.

Test Plan:
- ADD a=0x9 b=0x8, rsp_ready=1 -> alu_add high one cycle at T+1; rsp_valid at T+2 with data=0x1, flag=1, err=0.
- LSH a=0xA -> alu_lsr at T+1, alu_lsh at T+2; rsp at T+3 with data=0x4, flag=1. RSH a=0x3 -> data=0x1.
- SUB a=0x2 b=0x5 with rsp_ready held 0 for 4 cycles -> rsp_valid, data=0xD, flag=1 stable throughout; req_ready=0 until the handshake; a second req_valid is not accepted meanwhile.
- Back-to-back AND 0xC,0xA then XOR 0xC,0xA -> responses 0x8 then 0x6 in order, flag=0; never two strobes high in the same cycle.
- Reset pulled low in LOAD of an RSH -> next cycle IDLE, all strobes 0, rsp_valid=0; no response is ever produced for that request.
- Opcode 0xB:
  - With ALU_SEQ_ILLEGAL_TRAP_EN: rsp at T+1 with err=1, data=0, no strobe.
  - Without it: alu_clr at T+1, rsp data=0, err=0.
